// File: rtl/lc3b_types.sv
// Shared LC-3b out-of-order core types: word/ROB tag widths, the CDB broadcast
// record and the CDB requester index map.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_rob_addr;

  typedef struct packed {
    logic         valid;
    lc3b_rob_addr tag;
    lc3b_word     value;
  } lc3b_cdb_t;

  localparam int NUM_CDB_REQ   = 4;
  localparam int CDB_REQ_ALU0  = 0;
  localparam int CDB_REQ_ALU1  = 1;
  localparam int CDB_REQ_ALU2  = 2;
  localparam int CDB_REQ_LDBUF = 3;

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping explicitly so NUM_REQ need not be a power of two.
module cdb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  logic w_found;
  int   w_cand;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = int'(ptr) + k;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      if (!w_found && req[w_cand]) begin
        w_found      = 1'b1;
        gnt[w_cand]  = 1'b1;
        idx          = PTR_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among result producers and a
// registered one-cycle CDB broadcast. Optional macro CDB_PERF_CNT_EN adds a
// saturating request-conflict counter output.
module cdb_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ,
  parameter int TAG_W   = $bits(lc3b_rob_addr),
  parameter int DATA_W  = $bits(lc3b_word)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_value,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_value
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [15:0]            perf_conflict_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   r_ptr;
  logic               r_cdb_valid;
  logic [TAG_W-1:0]   r_cdb_tag;
  logic [DATA_W-1:0]  r_cdb_value;

  logic [NUM_REQ-1:0] w_req_eff;
  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_idx;
  logic               w_any;
  lc3b_cdb_t          w_cdb;

  // Flush and reset mask every request so no grant can escape in those cycles.
  assign w_req_eff = (flush || rst) ? '0 : req;

  cdb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (w_req_eff),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  assign w_any = |w_gnt;
  assign gnt   = w_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
    end else if (w_any) begin
      r_cdb_valid <= 1'b1;
      r_cdb_tag   <= req_tag[w_idx*TAG_W +: TAG_W];
      r_cdb_value <= req_value[w_idx*DATA_W +: DATA_W];
      r_ptr       <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign w_cdb.valid = r_cdb_valid;
  assign w_cdb.tag   = r_cdb_tag;
  assign w_cdb.value = r_cdb_value;

  assign cdb_valid = w_cdb.valid;
  assign cdb_tag   = w_cdb.tag;
  assign cdb_value = w_cdb.value;

`ifdef CDB_PERF_CNT_EN
  logic [15:0] r_perf_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cnt <= '0;
    end else if (!flush && ($countones(req) >= 2) && (r_perf_cnt != 16'hFFFF)) begin
      r_perf_cnt <= r_perf_cnt + 16'd1;
    end
  end

  assign perf_conflict_cnt = r_perf_cnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: reset, single request, contention,
// wrap, flush and (with CDB_PERF_CNT_EN) the conflict counter.
module tb_cdb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 3;
  localparam int DATA_W  = 16;

  logic                       clk;
  logic                       rst;
  logic                       flush;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*TAG_W-1:0]   req_tag;
  logic [NUM_REQ*DATA_W-1:0]  req_value;
  logic [NUM_REQ-1:0]         gnt;
  logic                       cdb_valid;
  logic [TAG_W-1:0]           cdb_tag;
  logic [DATA_W-1:0]          cdb_value;
`ifdef CDB_PERF_CNT_EN
  logic [15:0]                perf_conflict_cnt;
`endif

  int checks;
  int errors;

  cdb_arbiter #(
    .NUM_REQ (NUM_REQ),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req       (req),
    .req_tag   (req_tag),
    .req_value (req_value),
    .gnt       (gnt),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value)
`ifdef CDB_PERF_CNT_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_value[i*DATA_W +: DATA_W] = v;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    req       = 4'b1111;
    req_tag   = '0;
    req_value = '0;
    #3;
    // Reset state, grant masked while rst is high
    chk("rst_gnt",   32'(gnt),       32'h0);
    chk("rst_valid", 32'(cdb_valid), 32'h0);
    chk("rst_tag",   32'(cdb_tag),   32'h0);
    chk("rst_value", 32'(cdb_value), 32'h0);
    step();
    req = 4'b0000;
    step();
    rst = 1'b0;

    // Single request from ptr=0
    req = 4'b0001;
    set_src(0, 3'd5, 16'h1234);
    #1;
    chk("single_gnt", 32'(gnt), 32'h1);
    step();
    req = 4'b0000;
    chk("single_valid", 32'(cdb_valid), 32'h1);
    chk("single_tag",   32'(cdb_tag),   32'h5);
    chk("single_value", 32'(cdb_value), 32'h1234);
    step();
    chk("single_valid_drop", 32'(cdb_valid), 32'h0);
    chk("single_tag_hold",   32'(cdb_tag),   32'h5);
    chk("single_value_hold", 32'(cdb_value), 32'h1234);

    // ptr=1 now: grant requester 2, then reset mid-cycle while broadcast valid
    req = 4'b0100;
    set_src(2, 3'd6, 16'hABCD);
    #1;
    chk("pre_rst_gnt", 32'(gnt), 32'h4);
    step();
    req = 4'b0000;
    chk("pre_rst_valid", 32'(cdb_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(cdb_valid), 32'h0);
    chk("midrst_tag",   32'(cdb_tag),   32'h0);
    chk("midrst_value", 32'(cdb_value), 32'h0);
    #2;
    rst = 1'b0;

    // Full contention from ptr=0, each requester drops on its grant
    req = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_src(i, TAG_W'(i + 1), DATA_W'(16'h1111 * (i + 1)));
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      chk($sformatf("cont_gnt%0d", k), 32'(gnt), 32'(1 << k));
      step();
      req[k] = 1'b0;
      chk($sformatf("cont_valid%0d", k), 32'(cdb_valid), 32'h1);
      chk($sformatf("cont_tag%0d", k),   32'(cdb_tag),   32'(k + 1));
      chk($sformatf("cont_value%0d", k), 32'(cdb_value), 32'(16'h1111 * (k + 1)));
    end
    step();
    chk("cont_idle_valid", 32'(cdb_valid), 32'h0);

    // Wrap: grant 2 (ptr->3), then 0011 wraps to requester 0, then 0010 -> 1
    req = 4'b0100;
    #1;
    chk("wrap_g2", 32'(gnt), 32'h4);
    step();
    req = 4'b0011;
    #1;
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    step();
    chk("wrap_tag0", 32'(cdb_tag), 32'h1);
    req = 4'b0010;
    #1;
    chk("wrap_gnt1", 32'(gnt), 32'h2);
    step();
    req = 4'b0000;
    chk("wrap_tag1", 32'(cdb_tag), 32'h2);

    // Flush: ptr=2, all requesting, flush wins; ptr unchanged afterwards
    req   = 4'b1111;
    flush = 1'b1;
    #1;
    chk("flush_gnt", 32'(gnt), 32'h0);
    step();
    chk("flush_valid", 32'(cdb_valid), 32'h0);
    flush = 1'b0;
    #1;
    chk("post_flush_gnt", 32'(gnt), 32'h4);
    step();
    req = 4'b0000;
    chk("post_flush_tag", 32'(cdb_tag), 32'h3);
    step();

`ifdef CDB_PERF_CNT_EN
    // Counter cleared by reset, ignores flush cycles, counts cycles with >=2 requests
    rst = 1'b1;
    #1;
    chk("perf_rst", 32'(perf_conflict_cnt), 32'h0);
    rst = 1'b0;
    req   = 4'b1111;
    flush = 1'b1;
    step();
    flush = 1'b0;
    req   = 4'b0000;
    chk("perf_flush", 32'(perf_conflict_cnt), 32'h0);
    req = 4'b0111;
    #1;
    chk("perf_gnt0", 32'(gnt), 32'h1);
    step();
    req = 4'b0110;
    step();
    req = 4'b0100;
    step();
    req = 4'b0000;
    chk("perf_cnt", 32'(perf_conflict_cnt), 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the single Common Data Bus (CDB) among result producers: 3 ALU reservation stations and the load buffer.
- Selects at most one requester per cycle using round-robin and drives the registered CDB broadcast.
- The broadcast is consumed by the reorder buffer, the reservation stations, the load buffer and issue control.
- Returns a one-hot grant so the winning producer can retire its result.

Parameters:
- NUM_REQ, 4, number of CDB requesters (index 0-2 ALU RS, 3 load buffer).
- TAG_W, 3, ROB tag width (width of lc3b_rob_addr).
- DATA_W, 16, result width (width of lc3b_word).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush from commit; kills arbitration this cycle.
- req  in  NUM_REQ  per-requester result-ready.
- req_tag  in  NUM_REQ*TAG_W  per-requester ROB destination tag, packed, requester i at [i*TAG_W +: TAG_W].
- req_value  in  NUM_REQ*DATA_W  per-requester result value, packed the same way.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- cdb_valid  out  1  registered CDB broadcast valid.
- cdb_tag  out  TAG_W  registered broadcast ROB tag.
- cdb_value  out  DATA_W  registered broadcast value.

Behaviour:
- State: round-robin pointer ptr (clog2(NUM_REQ) bits), plus the cdb_valid, cdb_tag and cdb_value registers.
- Reset (async, rst=1): ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0, effective immediately. gnt=0 while rst is high.
- Grant (combinational): scan indices ptr, ptr+1, ..., wrapping at NUM_REQ-1 to 0. The first i with req[i]=1 wins, gnt[i]=1.
  - gnt=0 if no req, or if flush=1, or if rst=1.
  - gnt is always onehot0 and a subset of req.
- Clock edge with a grant k:
  - cdb_valid<=1, cdb_tag<=req_tag[k], cdb_value<=req_value[k].
  - ptr<=k+1, or 0 if k=NUM_REQ-1. Wrap is explicit; NUM_REQ need not be a power of 2.
- Clock edge with no grant:
  - cdb_valid<=0; cdb_tag and cdb_value hold their previous values.
  - ptr unchanged.
- Flush:
  - gnt=0 in the flush cycle; cdb_valid<=0 at that edge; ptr unchanged.
  - Requesters clear their own entries on flush, so the arbiter keeps no pending state.
- Latency: a result granted in cycle t is on the CDB for exactly one cycle, t+1. Throughput is one broadcast per cycle.
- Handshake:
  - A requester holds req, tag and value stable until it sees gnt=1.
  - At the edge where gnt=1 it drops req or presents a new result.
  - The arbiter never latches a request that was not granted.
- Fairness: a continuously asserted requester is granted within NUM_REQ-1 cycles of its first assertion; no starvation.
- Reset mid-operation: the registered broadcast is discarded, and no partial CDB cycle is ever visible.
- Simultaneous flush and a grant-eligible request: flush wins.

Optional Feature:
- Macro CDB_PERF_CNT_EN.
- Defined:
  - Adds output port perf_conflict_cnt, 16 bits, reset to 0.
  - Increments (saturating at 0xFFFF) on every edge where flush=0 and popcount(req)>=2.
  - Cleared by rst and not by flush.
- Undefined: the port and the counter are absent; arbitration behaviour is identical.

Decomposition:
- Package lc3b_types holds:
  - lc3b_word and lc3b_rob_addr.
  - The CDB struct {valid, tag, value}; the top level packs the cdb_* outputs into it.
  - Constant NUM_CDB_REQ=4 and the requester index constants CDB_REQ_ALU0..2 and CDB_REQ_LDBUF.
- One combinational sub-module, cdb_rr_pick:
  - Inputs req and ptr; outputs one-hot gnt and the encoded winner index.
  - The top level holds all registers.

Test Plan:
- Reset: assert rst mid-cycle while cdb_valid=1 -> cdb_valid=0, cdb_tag=0 and cdb_value=0 immediately; first grant after release uses ptr=0.
- Single request: req=0001, tag=5, value=0x1234 -> gnt=0001 the same cycle; next cycle cdb_valid=1, tag=5, value=0x1234; the cycle after, cdb_valid=0.
- Full contention: req=1111 held, each requester dropping on its grant, tags 1,2,3,4, from ptr=0 -> grants 0,1,2,3 on consecutive cycles; CDB shows tags 1,2,3,4 back to back.
- Wrap: after granting 2 (ptr=3), apply req=0011 -> gnt=0001; next ptr=1; next cycle with req=0010 -> gnt=0010.
- Flush: req=1111 with flush=1 -> gnt=0000; next cycle cdb_valid=0; ptr is unchanged and arbitration resumes from it after flush drops.
- Perf (CDB_PERF_CNT_EN): req=0111 held, each requester dropping on its grant, over 3 cycles -> counter ends at 2 (cycles with 3 then 2 requesters); flush cycles are not counted.
